dictionary_sequencer: RTL
=========================

// Module: dictionary_sequencer
// PURPOSE
// - Phase controller for the dictionary materializer: gates the value-ingest and id-lookup handshakes so
//   values always load fully before any id enters, and ids never exceed the in-transit credit limit.
// - Sits beside the dictionary; only valid/ready/keep/last pass through it, payload data bypasses it.
// - Supports reuse of loaded contents across lookup batches and reports length/protocol errors.
// PARAMETERS
// - NUM_ELEMENTS    8     lanes per beat (keep width)
// - MAX_VALUES      4096  dictionary capacity in values
// - MAX_IN_TRANSIT  64    max id beats accepted but not yet returned on out
// PORTS
// - clk              in   1                clock
// - rst_n            in   1                async active-low reset
// - cfg_valid/ready  in/out 1              batch start handshake
// - cfg_num_values   in   $clog2(MAX_VALUES+1)  values expected in load phase
// - cfg_reload       in   1                1: load new values; 0: reuse loaded contents
// - vin_valid/ready  in/out 1              upstream value stream handshake
// - vin_keep, vin_last  in  NUM_ELEMENTS,1 value stream sideband
// - vout_valid/ready out/in 1              gated value handshake toward dictionary
// - iin_valid/ready  in/out 1              upstream id stream handshake
// - iin_last         in   1                id stream last
// - iout_valid/ready out/in 1              gated id handshake toward dictionary
// - res_valid/ready/last in 1 each         dictionary output observation (monitor only)
// - busy             out  1                state != IDLE
// - done             out  1                one-cycle pulse at end of lookup batch
// - err              out  3                sticky {proto, len, cfg}; cleared only by reset
// - value_count      out  $clog2(MAX_VALUES+1)  values accepted in current/last load
// BEHAVIOUR
// - Reset: state IDLE, all ready/valid outs 0, busy/done 0, err 0, counters 0, loaded flag 0.
// - Gates combinational, zero latency: vout_valid=vin_valid&&open_v, vin_ready=vout_ready&&open_v; ids same.
// - IDLE: cfg_ready=1. On cfg handshake: num_values==0, or >MAX_VALUES, or (reload=0 && !loaded)
//   -> set err.cfg, stay IDLE. Else reload=1 -> LOAD (clear value_count, loaded=0); reload=0 -> LOOKUP.
// - LOAD: open_v=1, open_i=0. Per accepted beat value_count += popcount(vin_keep), saturating at MAX_VALUES.
//   On accepted vin_last -> LOOKUP, loaded=1; set err.len if final count != num_values.
// - LOOKUP: open_v=0, open_i = (in_flight < MAX_IN_TRANSIT). in_flight +1 per accepted id beat,
//   -1 per res handshake, unchanged when both same cycle. On accepted iin_last -> DRAIN.
// - DRAIN: both gates closed. On res handshake with res_last -> DONE.
// - DONE: done=1 for exactly this cycle, in_flight must read 0 else err.proto; next cycle IDLE.
// - err.proto also set by res handshake in IDLE/LOAD, or by decrement at in_flight==0 (counter holds 0).
// - Single-beat lookup (first id beat carries last): LOOKUP -> DRAIN on that beat.
// - Load beat with keep==0 counts 0; with last it still ends the phase.
// - Reset mid-operation: immediate return to IDLE, loaded=0; upstream must restart with cfg.
// STRUCTURE
// - dictionary_pkg: state enum {IDLE,LOAD,LOOKUP,DRAIN,DONE}, err bit indices, count width function.
// - Sub-module credit_counter (up/down, saturating, full/empty flags) for in_flight; FSM + popcount inline.
// TESTING
// - cfg(16,reload=1); 2 beats keep=8'hFF, 2nd last -> value_count=16, err=0, LOOKUP; ids blocked until then.
// - After load, 70 id beats with res_ready=0 -> exactly 64 accepted, iin_ready=0; one res beat -> one more id.
// - cfg(16,1), single beat keep=8'h0F last -> value_count=4, err.len=1, proceeds to LOOKUP.
// - Lookup 3 beats, res 3 beats last on 3rd -> done pulses 1 cycle, busy 0 next; then cfg(0? no: 16,0) -> LOOKUP directly.
// - cfg(reload=0) right after reset -> err.cfg=1, stays IDLE; res handshake in IDLE -> err.proto=1.
// - Assert rst_n low mid-LOOKUP with 10 in flight -> next edge IDLE, all readies 0, err 0, loaded 0.

Source files
------------

// File: rtl/dictionary_pkg.sv
// Shared types and helpers for the dictionary phase controller.
package dictionary_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_LOOKUP,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // err bit positions: err = {proto, len, cfg}
   localparam int ERR_CFG   = 0;
   localparam int ERR_LEN   = 1;
   localparam int ERR_PROTO = 2;
   localparam int ERR_W     = 3;

   function automatic int cnt_width(input int max_count);
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/credit_counter.sv
// Up/down in-flight counter; saturates at MAX_COUNT and holds at zero.
module credit_counter
   import dictionary_pkg::*;
#(
   parameter int MAX_COUNT = 64
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             inc_i,
   input  logic                             dec_i,
   output logic [$clog2(MAX_COUNT+1)-1:0]   count_o,
   output logic                             full_o,
   output logic                             empty_o
);

   localparam int CW = cnt_width(MAX_COUNT);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != MAX_C)) begin
         count_d = count_q + CW'(1);
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign full_o  = (count_q == MAX_C);
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/dictionary_sequencer.sv
// Phase controller gating value-load and id-lookup handshakes of the dictionary.
//   state  | meaning
//   IDLE   | waiting for batch cfg
//   LOAD   | value stream open, counting kept lanes
//   LOOKUP | id stream open while in-flight credit remains
//   DRAIN  | both gates closed, waiting for last result
//   DONE   | one-cycle batch-complete pulse
module dictionary_sequencer
   import dictionary_pkg::*;
#(
   parameter int NUM_ELEMENTS   = 8,
   parameter int MAX_VALUES     = 4096,
   parameter int MAX_IN_TRANSIT = 64
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              cfg_valid_i,
   output logic                              cfg_ready_o,
   input  logic [$clog2(MAX_VALUES+1)-1:0]   cfg_num_values_i,
   input  logic                              cfg_reload_i,
   input  logic                              vin_valid_i,
   output logic                              vin_ready_o,
   input  logic [NUM_ELEMENTS-1:0]           vin_keep_i,
   input  logic                              vin_last_i,
   output logic                              vout_valid_o,
   input  logic                              vout_ready_i,
   input  logic                              iin_valid_i,
   output logic                              iin_ready_o,
   input  logic                              iin_last_i,
   output logic                              iout_valid_o,
   input  logic                              iout_ready_i,
   input  logic                              res_valid_i,
   input  logic                              res_ready_i,
   input  logic                              res_last_i,
   output logic                              busy_o,
   output logic                              done_o,
   output logic [ERR_W-1:0]                  err_o,
   output logic [$clog2(MAX_VALUES+1)-1:0]   value_count_o
);

   localparam int VCW = cnt_width(MAX_VALUES);
   localparam int PCW = cnt_width(NUM_ELEMENTS);
   localparam int ICW = cnt_width(MAX_IN_TRANSIT);
   localparam logic [VCW-1:0] MAX_V = VCW'(MAX_VALUES);

   state_e           state_q, state_d;
   logic [VCW-1:0]   num_q, num_d;
   logic [VCW-1:0]   vcnt_q, vcnt_d;
   logic             loaded_q, loaded_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             live_q;

   logic             open_v, open_i;
   logic             v_acc, i_acc, res_hs, cfg_hs;
   logic [PCW-1:0]   keep_pop;
   logic [VCW:0]     vsum;
   logic [VCW-1:0]   vcnt_sat;
   logic [ICW-1:0]   in_flight;
   logic             cred_full, cred_empty;

   assign vout_valid_o = vin_valid_i && open_v;
   assign vin_ready_o  = vout_ready_i && open_v;
   assign iout_valid_o = iin_valid_i && open_i;
   assign iin_ready_o  = iout_ready_i && open_i;

   assign v_acc  = vin_valid_i && vout_ready_i && open_v;
   assign i_acc  = iin_valid_i && iout_ready_i && open_i;
   assign res_hs = res_valid_i && res_ready_i;
   assign cfg_hs = cfg_valid_i && cfg_ready_o;

   always_comb begin
      keep_pop = '0;
      for (int k = 0; k < NUM_ELEMENTS; k++) begin
         keep_pop = keep_pop + PCW'(vin_keep_i[k]);
      end
   end

   assign vsum     = {1'b0, vcnt_q} + (VCW+1)'(keep_pop);
   assign vcnt_sat = (vsum > {1'b0, MAX_V}) ? MAX_V : vsum[VCW-1:0];

   credit_counter #(
      .MAX_COUNT (MAX_IN_TRANSIT)
   ) u_credit (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (i_acc),
      .dec_i   (res_hs),
      .count_o (in_flight),
      .full_o  (cred_full),
      .empty_o (cred_empty)
   );

   always_comb begin
      state_d     = state_q;
      num_d       = num_q;
      vcnt_d      = vcnt_q;
      loaded_d    = loaded_q;
      err_d       = err_q;
      open_v      = 1'b0;
      open_i      = 1'b0;
      cfg_ready_o = 1'b0;
      done_o      = 1'b0;

      // a result returned with nothing outstanding is a protocol error
      if (res_hs && !i_acc && cred_empty) begin
         err_d[ERR_PROTO] = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            cfg_ready_o = live_q;
            if (res_hs) begin
               err_d[ERR_PROTO] = 1'b1;
            end
            if (cfg_hs) begin
               if ((cfg_num_values_i == '0) || (cfg_num_values_i > MAX_V) ||
                   (!cfg_reload_i && !loaded_q)) begin
                  err_d[ERR_CFG] = 1'b1;
               end else begin
                  num_d = cfg_num_values_i;
                  if (cfg_reload_i) begin
                     vcnt_d   = '0;
                     loaded_d = 1'b0;
                     state_d  = ST_LOAD;
                  end else begin
                     state_d  = ST_LOOKUP;
                  end
               end
            end
         end
         ST_LOAD: begin
            open_v = 1'b1;
            if (res_hs) begin
               err_d[ERR_PROTO] = 1'b1;
            end
            if (v_acc) begin
               vcnt_d = vcnt_sat;
               if (vin_last_i) begin
                  loaded_d = 1'b1;
                  state_d  = ST_LOOKUP;
                  if (vcnt_sat != num_q) begin
                     err_d[ERR_LEN] = 1'b1;
                  end
               end
            end
         end
         ST_LOOKUP: begin
            open_i = !cred_full;
            if (i_acc && iin_last_i) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (res_hs && res_last_i) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o = 1'b1;
            if (in_flight != '0) begin
               err_d[ERR_PROTO] = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // live_q keeps cfg_ready low while reset is held and for one cycle after
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         num_q    <= '0;
         vcnt_q   <= '0;
         loaded_q <= 1'b0;
         err_q    <= '0;
         live_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         num_q    <= num_d;
         vcnt_q   <= vcnt_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
         live_q   <= 1'b1;
      end
   end

   assign busy_o        = (state_q != ST_IDLE);
   assign err_o         = err_q;
   assign value_count_o = vcnt_q;

endmodule
